// File: rtl/m_ext_issue_ctrl.sv
// EX-stage issue/stall/write-back control for RV32M multiplies driving an iterative multiplier.
// Optional one-entry result cache enabled by defining MUL_RESULT_CACHE_EN.
module m_ext_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int XLEN           = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_e,
   input  logic [6:0]      opcode_e,
   input  logic [2:0]      funct3_e,
   input  logic [6:0]      funct7_e,
   input  logic [4:0]      rd_e,
   input  logic [XLEN-1:0] rs1_data_e,
   input  logic [XLEN-1:0] rs2_data_e,
   input  logic            flush,
   input  logic            mul_done,
   input  logic [XLEN-1:0] mul_result,
   output logic            start_e,
   output logic [1:0]      mul_opcode,
   output logic [XLEN-1:0] operand1,
   output logic [XLEN-1:0] operand2,
   output logic            stall_pipe,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            err_timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

   state_t          state_q, state_d;
   logic            start_q, start_d;
   logic            stall_q, stall_d;
   logic            wbv_q, wbv_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] op1_q, op1_d;
   logic [XLEN-1:0] op2_q, op2_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] wbd_q, wbd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   logic            is_mul, accept, cache_hit;
   logic [XLEN-1:0] cache_res;

   assign is_mul = valid_e & (opcode_e == 7'b0110011) & (funct7_e == 7'b0000001) & ~funct3_e[2];
   assign accept = (state_q == S_IDLE) & is_mul & ~flush;

`ifdef MUL_RESULT_CACHE_EN
   logic            c_vld_q;
   logic [1:0]      c_op_q;
   logic [XLEN-1:0] c_rs1_q, c_rs2_q, c_res_q;

   assign cache_hit = c_vld_q & (c_op_q == funct3_e[1:0]) &
                      (c_rs1_q == rs1_data_e) & (c_rs2_q == rs2_data_e);
   assign cache_res = c_res_q;

   // Filled from the committed op in WB; any flush drops the entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_vld_q <= 1'b0;
         c_op_q  <= '0;
         c_rs1_q <= '0;
         c_rs2_q <= '0;
         c_res_q <= '0;
      end else if (flush) begin
         c_vld_q <= 1'b0;
      end else if (state_q == S_WB) begin
         c_vld_q <= 1'b1;
         c_op_q  <= op_q;
         c_rs1_q <= op1_q;
         c_rs2_q <= op2_q;
         c_res_q <= wbd_q;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cache_res = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = cache_hit ? S_WB : S_ISSUE;
         S_ISSUE: state_d = flush ? S_IDLE : S_WAIT;
         S_WAIT:  if (flush) state_d = S_IDLE;
                  else if (mul_done) state_d = S_WB;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values for the registered outputs; everything below is a flop.
   always_comb begin
      start_d = 1'b0;
      stall_d = 1'b0;
      wbv_d   = 1'b0;
      op_d    = op_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      rd_d    = rd_q;
      wbd_d   = wbd_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = funct3_e[1:0];
               op1_d   = rs1_data_e;
               op2_d   = rs2_data_e;
               rd_d    = rd_e;
               cnt_d   = '0;
               stall_d = 1'b1;
               if (cache_hit) begin
                  wbv_d = 1'b1;
                  wbd_d = cache_res;
               end else begin
                  start_d = 1'b1;
               end
            end
         end
         S_ISSUE: stall_d = ~flush;
         S_WAIT: begin
            if (cnt_q != CW'(TIMEOUT_CYCLES)) cnt_d = cnt_q + CW'(1);
            else                              err_d = 1'b1;
            if (!flush) begin
               if (mul_done) begin
                  wbd_d = mul_result;
                  wbv_d = 1'b1;
               end else begin
                  stall_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= 1'b0;
         stall_q <= 1'b0;
         wbv_q   <= 1'b0;
         op_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         rd_q    <= '0;
         wbd_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         start_q <= start_d;
         stall_q <= stall_d;
         wbv_q   <= wbv_d;
         op_q    <= op_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         rd_q    <= rd_d;
         wbd_q   <= wbd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign start_e     = start_q;
   assign stall_pipe  = stall_q;
   assign wb_valid    = wbv_q;
   assign mul_opcode  = op_q;
   assign operand1    = op1_q;
   assign operand2    = op2_q;
   assign wb_rd       = rd_q;
   assign wb_data     = wbd_q;
   assign err_timeout = err_q;

endmodule
